// File: rtl/note_seq_buffer.sv
// note_seq_buffer: record/playback note sequencer.
// Captures {note, octave} events into a DEPTH-entry register array while idle,
// then replays them with NOTE_TICKS of sound and GAP_TICKS of silence per entry.
// Every output is registered; full/empty decode the registered count.
module note_seq_buffer #(
  parameter int DEPTH      = 16,
  parameter int NOTE_W     = 4,
  parameter int OCT_W      = 2,
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 2500000,
  parameter int TICK_W     = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rec_valid,
  input  logic [NOTE_W-1:0]          note_in,
  input  logic [OCT_W-1:0]           octave_in,
  input  logic                       play_start,
  input  logic                       stop,
  input  logic                       clear,
  input  logic                       loop_en,
  output logic                       playing,
  output logic                       note_valid,
  output logic [NOTE_W-1:0]          note_out,
  output logic [OCT_W-1:0]           octave_out,
  output logic                       step_pulse,
  output logic [$clog2(DEPTH)-1:0]   play_index,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = NOTE_W + OCT_W;
  localparam bit HAS_GAP = (GAP_TICKS > 0);
  localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = HAS_GAP ? TICK_W'(GAP_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [TICK_W-1:0] timer;
  logic [TICK_W-1:0] timer_n;
  logic [IDX_W-1:0]  idx_n;
  logic [CNT_W-1:0]  count_n;
  logic              ovf_n;
  logic              step_n;
  logic              wr_en;
  logic              adv;
  logic              last_entry;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  rd_ent;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign last_entry = ((CNT_W'(play_index) + CNT_W'(1)) >= count);
  // Entry that will be presented next cycle; the array read is absorbed by the output register.
  assign rd_ent     = mem[idx_n];

  // Next-state, timer, index and buffer bookkeeping; clear outranks everything.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = play_index;
    count_n = count;
    ovf_n   = overflow;
    step_n  = 1'b0;
    wr_en   = 1'b0;
    adv     = 1'b0;
    if (clear) begin
      state_n = IDLE;
      timer_n = '0;
      idx_n   = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer_n = '0;
          if (play_start && !empty) begin
            state_n = NOTE;
            idx_n   = '0;
            step_n  = 1'b1;
          end else if (rec_valid) begin
            if (full) begin
              ovf_n = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_n = count + CNT_W'(1);
            end
          end
        end
        NOTE: begin
          if (stop) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == NOTE_LAST) begin
            timer_n = '0;
            if (HAS_GAP) state_n = GAP;
            else         adv     = 1'b1;
          end else begin
            timer_n = timer + TICK_W'(1);
          end
        end
        GAP: begin
          if (stop) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == GAP_LAST) begin
            timer_n = '0;
            adv     = 1'b1;
          end else begin
            timer_n = timer + TICK_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
      // Leaving an entry: step forward, wrap when looping, otherwise go idle holding the index.
      if (adv) begin
        if (!last_entry) begin
          idx_n   = play_index + IDX_W'(1);
          state_n = NOTE;
          step_n  = 1'b1;
        end else if (loop_en) begin
          idx_n   = '0;
          state_n = NOTE;
          step_n  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    end
  end

  // Control state and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      play_index <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      playing    <= 1'b0;
      note_valid <= 1'b0;
      note_out   <= '0;
      octave_out <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      play_index <= idx_n;
      count      <= count_n;
      overflow   <= ovf_n;
      playing    <= (state_n != IDLE);
      note_valid <= (state_n == NOTE);
      note_out   <= (state_n == NOTE) ? rd_ent[ENT_W-1:OCT_W] : '0;
      octave_out <= (state_n == NOTE) ? rd_ent[OCT_W-1:0] : '0;
      step_pulse <= step_n;
    end
  end

  // Note storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[IDX_W'(count)] <= {note_in, octave_in};
  end

endmodule

// File: tb/tb_note_seq_buffer.sv
// tb_note_seq_buffer: directed bench for note_seq_buffer.
// Instance dut uses a 2-cycle gap, instance dut0 has no gap.
module tb_note_seq_buffer;

  logic       clk = 1'b0;
  logic       reset;

  logic       rec_valid, play_start, stop, clear, loop_en;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       playing, note_valid, step_pulse, full, empty, overflow;
  logic [3:0] note_out;
  logic [1:0] octave_out, play_index;
  logic [2:0] count;

  logic       rec_valid0, play_start0, stop0, clear0, loop_en0;
  logic [3:0] note_in0;
  logic [1:0] octave_in0;
  logic       playing0, note_valid0, step_pulse0, full0, empty0, overflow0;
  logic [3:0] note_out0;
  logic [1:0] octave_out0, play_index0;
  logic [2:0] count0;

  int n_chk = 0;
  int n_err = 0;

  int n_tab [3] = '{5, 7, 1};
  int o_tab [3] = '{1, 2, 0};
  int z_tab [3] = '{3, 5, 8};

  always #5 clk = ~clk;

  note_seq_buffer #(
    .DEPTH(4), .NOTE_W(4), .OCT_W(2), .NOTE_TICKS(4), .GAP_TICKS(2), .TICK_W(4)
  ) dut (
    .clk(clk), .reset(reset), .rec_valid(rec_valid), .note_in(note_in),
    .octave_in(octave_in), .play_start(play_start), .stop(stop), .clear(clear),
    .loop_en(loop_en), .playing(playing), .note_valid(note_valid),
    .note_out(note_out), .octave_out(octave_out), .step_pulse(step_pulse),
    .play_index(play_index), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  note_seq_buffer #(
    .DEPTH(4), .NOTE_W(4), .OCT_W(2), .NOTE_TICKS(4), .GAP_TICKS(0), .TICK_W(4)
  ) dut0 (
    .clk(clk), .reset(reset), .rec_valid(rec_valid0), .note_in(note_in0),
    .octave_in(octave_in0), .play_start(play_start0), .stop(stop0), .clear(clear0),
    .loop_en(loop_en0), .playing(playing0), .note_valid(note_valid0),
    .note_out(note_out0), .octave_out(octave_out0), .step_pulse(step_pulse0),
    .play_index(play_index0), .count(count0), .full(full0), .empty(empty0),
    .overflow(overflow0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input logic [3:0] n, input logic [1:0] o);
    note_in = n; octave_in = o; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic rec0(input logic [3:0] n, input logic [1:0] o);
    note_in0 = n; octave_in0 = o; rec_valid0 = 1'b1;
    tick();
    rec_valid0 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rec_valid = 0; play_start = 0; stop = 0; clear = 0; loop_en = 0;
    note_in = 0; octave_in = 0;
    rec_valid0 = 0; play_start0 = 0; stop0 = 0; clear0 = 0; loop_en0 = 0;
    note_in0 = 0; octave_in0 = 0;
    tick(); tick();
    chk("rst_playing", playing, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_note_out", note_out, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick();

    // Mid-idle asynchronous reset with three entries stored
    rec(4'd2, 2'd2); rec(4'd3, 2'd3); rec(4'd4, 2'd0);
    chk("pre_rst_count", count, 3);
    reset = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_overflow", overflow, 0);
    #1;
    reset = 1'b1;
    tick();

    rec(4'd5, 2'd1); rec(4'd7, 2'd2); rec(4'd1, 2'd0);
    chk("rec3_count", count, 3);
    chk("rec3_full", full, 0);
    chk("rec3_empty", empty, 0);

    // Single pass, no loop: 4 note cycles + 2 gap cycles per entry
    loop_en = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      int e, p;
      e = (k - 1) / 6;
      p = (k - 1) % 6;
      if (k <= 18) begin
        chk($sformatf("sp_playing_k%0d", k), playing, 1);
        chk($sformatf("sp_nv_k%0d", k), note_valid, (p < 4) ? 1 : 0);
        chk($sformatf("sp_note_k%0d", k), note_out, (p < 4) ? n_tab[e] : 0);
        chk($sformatf("sp_oct_k%0d", k), octave_out, (p < 4) ? o_tab[e] : 0);
        chk($sformatf("sp_step_k%0d", k), step_pulse, (p == 0) ? 1 : 0);
        chk($sformatf("sp_idx_k%0d", k), play_index, e);
      end else begin
        chk($sformatf("sp_done_playing_k%0d", k), playing, 0);
        chk($sformatf("sp_done_nv_k%0d", k), note_valid, 0);
        chk($sformatf("sp_done_idx_k%0d", k), play_index, 2);
      end
      tick();
    end

    // Overflow: fifth record is dropped, fourth entry is retained
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", count, 0);
    rec(4'd1, 2'd1); rec(4'd2, 2'd2); rec(4'd3, 2'd3); rec(4'd4, 2'd0); rec(4'd6, 2'd1);
    chk("ovf_count", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    repeat (18) tick();
    chk("ovf_e3_note", note_out, 4);
    chk("ovf_e3_oct", octave_out, 0);
    chk("ovf_e3_idx", play_index, 3);
    chk("ovf_e3_step", step_pulse, 1);
    repeat (6) tick();
    chk("ovf_done_playing", playing, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_clr_count", count, 0);
    chk("ovf_clr_flag", overflow, 0);
    chk("ovf_clr_full", full, 0);

    // Looping two entries, then stop mid-note and restart
    rec(4'd9, 2'd3); rec(4'd2, 2'd1);
    chk("loop_count", count, 2);
    loop_en = 1'b1;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      chk($sformatf("loop_idx_k%0d", k), play_index, ((k - 1) / 6) % 2);
      chk($sformatf("loop_step_k%0d", k), step_pulse, ((k - 1) % 6 == 0) ? 1 : 0);
      if (k < 19) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_playing", playing, 0);
    chk("stop_nv", note_valid, 0);
    chk("stop_note", note_out, 0);
    chk("stop_oct", octave_out, 0);
    loop_en = 1'b0;
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("restart_idx", play_index, 0);
    chk("restart_note", note_out, 9);
    chk("restart_oct", octave_out, 3);
    chk("restart_step", step_pulse, 1);
    chk("restart_playing", playing, 1);

    // Recording is ignored during playback
    note_in = 4'd13; octave_in = 2'd1; rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    chk("recplay_count", count, 2);
    chk("recplay_ovf", overflow, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop2_playing", playing, 0);

    // play_start outranks rec_valid in the same idle cycle
    note_in = 4'd15; octave_in = 2'd2; rec_valid = 1'b1; play_start = 1'b1;
    tick();
    rec_valid = 1'b0; play_start = 1'b0;
    chk("prio_playing", playing, 1);
    chk("prio_count", count, 2);
    chk("prio_note", note_out, 9);

    // clear while playing silences outputs next cycle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrplay_playing", playing, 0);
    chk("clrplay_note", note_out, 0);
    chk("clrplay_empty", empty, 1);

    // play_start on an empty buffer does nothing
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    chk("empty_start_playing", playing, 0);
    chk("empty_start_step", step_pulse, 0);

    // No-gap build: notes run back to back
    rec0(4'd3, 2'd1); rec0(4'd5, 2'd2); rec0(4'd8, 2'd3);
    chk("g0_count", count0, 3);
    play_start0 = 1'b1;
    tick();
    play_start0 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 12) begin
        chk($sformatf("g0_nv_k%0d", k), note_valid0, 1);
        chk($sformatf("g0_note_k%0d", k), note_out0, z_tab[(k - 1) / 4]);
        chk($sformatf("g0_step_k%0d", k), step_pulse0, ((k - 1) % 4 == 0) ? 1 : 0);
      end else begin
        chk("g0_done_playing", playing0, 0);
        chk("g0_done_nv", note_valid0, 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/note_seq_buffer.md
Name: note_seq_buffer

Overview:
- Parametrised record/playback sequencer for the music device.
- Captures note/octave events from the keyboard conversion stage into a DEPTH-entry buffer, then replays them with programmable note and gap durations.
- Drives note/octave into the frequency datapath, plus a step pulse for the display/next-note logic.
- Generalises the fixed 16-note control/datapath pair: depth, field widths, timing, looping, stop and overflow reporting are new.

Parameters:
DEPTH, 16, number of buffer entries (>=2)
NOTE_W, 4, note code width
OCT_W, 2, octave code width
NOTE_TICKS, 12500000, clk cycles each note sounds (>=1; 0.25 s at 50 MHz)
GAP_TICKS, 2500000, silent clk cycles after each note (0 = no gap)
TICK_W, 24, timer width; must hold max(NOTE_TICKS, GAP_TICKS)

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-low reset (KEY[0])
rec_valid  in  1  one-cycle strobe: append note_in/octave_in
note_in  in  NOTE_W  note code to record
octave_in  in  OCT_W  octave code to record
play_start  in  1  one-cycle strobe: start playback from entry 0
stop  in  1  one-cycle strobe: abort playback
clear  in  1  one-cycle strobe: empty buffer, clear overflow
loop_en  in  1  level: restart at entry 0 after last entry
playing  out  1  high in NOTE or GAP state
note_valid  out  1  high only while a note sounds
note_out  out  NOTE_W  current note, 0 when note_valid=0
octave_out  out  OCT_W  current octave, 0 when note_valid=0
step_pulse  out  1  one-cycle pulse each time a new entry starts sounding
play_index  out  $clog2(DEPTH)  entry currently addressed
count  out  $clog2(DEPTH+1)  entries stored
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky: rec_valid arrived while full

Behaviour:
- Reset (async, reset=0): state IDLE; count=0, play_index=0, timer=0.
  - All outputs 0 except empty=1.
  - Buffer contents don't-care.
- All outputs are registered. Buffer is an inferred register array; no read latency beyond the output register.
- States: IDLE, NOTE, GAP.
- Input priority per cycle: clear > stop > play_start > rec_valid.
- clear:
  - Any state: count=0, overflow=0, play_index=0; state -> IDLE next cycle.
  - Outputs go quiet next cycle.
- stop in NOTE/GAP: -> IDLE next cycle; note_valid, playing, note_out, octave_out -> 0. Buffer untouched. In IDLE: no effect.
- rec_valid:
  - In IDLE, not full: mem[count] <= {note_in, octave_in}; count increments next cycle.
  - In IDLE, full: dropped; overflow <= 1.
  - In NOTE/GAP: ignored; overflow unaffected.
- play_start:
  - In IDLE with count>0 at cycle t: at t+1 state=NOTE, play_index=0, playing=1, note_valid=1, note_out/octave_out=mem[0], step_pulse=1.
  - In IDLE with count=0: ignored.
  - In NOTE/GAP: ignored; no restart.
- NOTE: note_valid stays high exactly NOTE_TICKS cycles, then:
  - GAP_TICKS>0: -> GAP.
  - GAP_TICKS=0: advance directly.
- GAP: note_valid=0, outputs zeroed, playing=1, for exactly GAP_TICKS cycles, then advance.
- Advance from entry i:
  - i<count-1: i+1 starts sounding the next cycle, with step_pulse.
  - i==count-1, loop_en=1: wrap to 0 with step_pulse.
  - i==count-1, loop_en=0: -> IDLE; playing=0; play_index holds last value.
  - loop_en is sampled at the advance instant.
- Timer: counts 0..N-1 within each state; reloads to 0 on each state/entry change; never wraps mid-note.
- full/empty derive combinationally from the registered count.

Test Plan:
- Setup for all scenarios: DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2.
- Reset then record: assert reset mid-idle with count=3 -> count=0, empty=1, overflow=0. Record (5,1),(7,2),(1,0) -> count=3, full=0.
- Single pass: play_start at t, loop_en=0 ->
  - note_valid high t+1..t+4 with note_out=5, octave_out=1; low t+5..t+6.
  - note_out=7 from t+7; step_pulse at t+1, t+7, t+13.
  - playing=0 from t+19.
- Overflow: record 5 entries -> count=4, full=1, overflow=1, mem[3] = 4th entry. clear -> count=0, overflow=0.
- Loop and stop:
  - loop_en=1 with 2 entries -> play_index 0,1,0,1; step_pulse every 6 cycles.
  - stop mid-NOTE -> next cycle playing=0, note_out=0.
  - Further play_start restarts at entry 0.
- Priority and guards:
  - play_start+rec_valid same cycle in IDLE -> playback starts, count unchanged.
  - play_start with empty=1 -> playing stays 0.
  - rec_valid during playback -> count unchanged, overflow=0.
- GAP_TICKS=0 build: 3 entries -> note_valid continuously high 12 cycles, note_out changes every 4 cycles, step_pulse every 4 cycles.
